// File: rtl/sw_watch_controller_if.sv
// sw_watch_controller_if
//   Bundles the button/mode inputs and the control outputs of the
//   stopwatch/watch mode controller.
//
//   Handshake: there is no valid/ready pair. Every btn_* line is a
//   single-cycle strobe that acts as its own "valid". The controller is
//   always ready, so it consumes each strobe in the cycle it is high and
//   nothing is ever held off or queued.
//
//   Signals (direction as seen by the controller, modport slave):
//     sw_mode      in   0 = stopwatch mode, 1 = watch mode (level)
//     btn_L/R/U/D  in   single-cycle debounced button pulses
//     sw_run       out  stopwatch counter enable
//     sw_clear     out  one-cycle stopwatch counter clear
//     lap_hold     out  stopwatch display freeze
//     set_active   out  watch is in a set state
//     set_field    out  00 none, 01 sec, 10 min, 11 hour
//     inc_pulse    out  one-cycle increment of the selected field
//     dec_pulse    out  one-cycle decrement of the selected field
//     blink        out  blink enable for the selected field digits
//     sw_state_dbg out  stopwatch FSM state (debug)
//     w_state_dbg  out  watch FSM state (debug)
//   modport master is the button/consumer side, modport slave the controller.
interface sw_watch_controller_if;
    logic       sw_mode;
    logic       btn_L;
    logic       btn_R;
    logic       btn_U;
    logic       btn_D;
    logic       sw_run;
    logic       sw_clear;
    logic       lap_hold;
    logic       set_active;
    logic [1:0] set_field;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       blink;
    logic [1:0] sw_state_dbg;
    logic [1:0] w_state_dbg;

    modport master (
        output sw_mode, btn_L, btn_R, btn_U, btn_D,
        input  sw_run, sw_clear, lap_hold, set_active, set_field,
        input  inc_pulse, dec_pulse, blink, sw_state_dbg, w_state_dbg
    );

    modport slave (
        input  sw_mode, btn_L, btn_R, btn_U, btn_D,
        output sw_run, sw_clear, lap_hold, set_active, set_field,
        output inc_pulse, dec_pulse, blink, sw_state_dbg, w_state_dbg
    );
endinterface

// File: rtl/sw_watch_controller.sv
// sw_watch_controller
//   Mode and sequence controller for the stopwatch/watch display system.
//   Two independent FSMs:
//     - stopwatch FSM (SW_STOP / SW_RUN / SW_CLEAR) drives run, clear and
//       lap-freeze for the stopwatch counter datapath;
//     - watch FSM (W_RUN / W_SET_HOUR / W_SET_MIN / W_SET_SEC) drives the
//       time-set editing of the watch datapath, with an inactivity timeout.
//   Buttons reach only the FSM selected by sw_mode in that cycle.
//
//   Ports:
//     clk  system clock
//     rst  synchronous, active-high reset
//     bus  sw_watch_controller_if.slave (buttons, mode, control outputs)
//
//   Parameters:
//     TIMEOUT_CYCLES  idle cycles in a set state before returning to W_RUN (>= 2)
//     BLINK_HALF      blink half-period in cycles (only used with BLINK_EN)
//
//   Optional feature macro: BLINK_EN. When defined, blink toggles every
//   BLINK_HALF cycles while editing; otherwise blink is tied to 0.
module sw_watch_controller #(
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int BLINK_HALF     = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    sw_watch_controller_if.slave bus
);
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        SW_STOP  = 2'd0,
        SW_RUN   = 2'd1,
        SW_CLEAR = 2'd2
    } sw_state_t;

    // Encoded so that the state value is directly the set_field code.
    typedef enum logic [1:0] {
        W_RUN      = 2'b00,
        W_SET_SEC  = 2'b01,
        W_SET_MIN  = 2'b10,
        W_SET_HOUR = 2'b11
    } w_state_t;

    sw_state_t         sw_state, sw_next;
    w_state_t          w_state, w_next;
    logic [IDLE_W-1:0] idle_cnt;
    logic              lap_q;
    logic              inc_q;
    logic              dec_q;

    logic sw_btn_l, sw_btn_r;
    logic w_btn_l, w_btn_r, w_btn_u, w_btn_d;
    logic any_btn, in_set, timeout, inc_req, dec_req;

    // Button routing by mode.
    assign sw_btn_l = bus.btn_L & ~bus.sw_mode;
    assign sw_btn_r = bus.btn_R & ~bus.sw_mode;
    assign w_btn_l  = bus.btn_L & bus.sw_mode;
    assign w_btn_r  = bus.btn_R & bus.sw_mode;
    assign w_btn_u  = bus.btn_U & bus.sw_mode;
    assign w_btn_d  = bus.btn_D & bus.sw_mode;
    assign any_btn  = bus.btn_L | bus.btn_R | bus.btn_U | bus.btn_D;
    assign in_set   = (w_state != W_RUN);

    // A press in the same cycle counts as activity, so it pre-empts the timeout.
    assign timeout  = in_set & (idle_cnt == IDLE_LAST) & ~any_btn;

    // L/R take priority over U/D; U and D together cancel each other.
    assign inc_req  = in_set & w_btn_u & ~w_btn_d & ~w_btn_r & ~w_btn_l;
    assign dec_req  = in_set & w_btn_d & ~w_btn_u & ~w_btn_r & ~w_btn_l;

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_state <= SW_STOP;
            w_state  <= W_RUN;
        end else begin
            sw_state <= sw_next;
            w_state  <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        sw_next = sw_state;
        case (sw_state)
            SW_STOP: begin
                if (sw_btn_r)      sw_next = SW_RUN;
                else if (sw_btn_l) sw_next = SW_CLEAR;
            end
            SW_RUN: begin
                if (sw_btn_r) sw_next = SW_STOP;
            end
            SW_CLEAR: sw_next = SW_STOP;
            default:  sw_next = SW_STOP;
        endcase
    end

    always_comb begin
        w_next = w_state;
        if (w_state == W_RUN) begin
            if (w_btn_l) w_next = W_SET_HOUR;
        end else if (!bus.sw_mode || w_btn_r || timeout) begin
            // Leaving watch mode aborts the edit.
            w_next = W_RUN;
        end else if (w_btn_l) begin
            case (w_state)
                W_SET_HOUR: w_next = W_SET_MIN;
                W_SET_MIN:  w_next = W_SET_SEC;
                default:    w_next = W_RUN;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q    <= 1'b0;
            idle_cnt <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            // lap_hold drops together with sw_clear and holds through SW_STOP.
            if (sw_next == SW_CLEAR)
                lap_q <= 1'b0;
            else if (sw_state == SW_RUN && sw_btn_l && !sw_btn_r)
                lap_q <= ~lap_q;

            // Counter stays at 0 in W_RUN and restarts on any activity.
            if (w_next == W_RUN || w_next != w_state || any_btn)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            inc_q <= inc_req;
            dec_q <= dec_req;
        end
    end

`ifdef BLINK_EN
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_q;
    logic               edit_press;

    assign edit_press = in_set & (w_btn_u | w_btn_d);

    // Restarting with blink = 1 keeps the digits visible right after a field
    // change or an edit.
    always_ff @(posedge clk) begin
        if (rst || w_next == W_RUN) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (w_next != w_state || edit_press) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    logic unused_blink_cfg;
    logic blink_q;
    assign unused_blink_cfg = (BLINK_HALF != 0);
    assign blink_q          = 1'b0;
`endif

    // ---------------- output decode ----------------
    always_comb begin
        bus.sw_run       = (sw_state == SW_RUN);
        bus.sw_clear     = (sw_state == SW_CLEAR);
        bus.lap_hold     = lap_q;
        bus.sw_state_dbg = sw_state;
    end

    always_comb begin
        bus.set_active  = in_set;
        bus.set_field   = w_state;
        bus.inc_pulse   = inc_q;
        bus.dec_pulse   = dec_q;
        bus.blink       = blink_q;
        bus.w_state_dbg = w_state;
    end
endmodule
